// File: rtl/jtpopeye_dma.sv
// jtpopeye_dma: copies LEN bytes of main RAM into the object buffer on every VB rising edge
// and flips the object buffer bank once the copy is done.
module jtpopeye_dma #(
  parameter logic [10:0] LEN = 11'd1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       VB,
  output logic       busrq_n,
  input  logic       busak_n,
  output logic       dma_cs,
  output logic [9:0] AD_DMA,
  input  logic [7:0] DD_DMA,
  output logic       obj_we,
  output logic [9:0] obj_addr,
  output logic [7:0] obj_data,
  output logic       obj_bank,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, REQ, COPY, FLUSH, REL} state_t;
  localparam int FLUSH_DEPTH = 2;
  state_t     r_st;
  logic       r_vbl;
  logic       r_fcnt;
  logic       r_rd_v;
  logic [9:0] r_rd_a;
  logic       w_start;
  logic       w_last;
  assign w_start = VB & ~r_vbl;
  assign w_last  = {1'b0, AD_DMA} == LEN - 11'd1;
  // r_rd_v/r_rd_a track the address the RAM sampled; its data lands one tick later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_vbl    <= 1'b0;
      r_fcnt   <= 1'b0;
      r_rd_v   <= 1'b0;
      r_rd_a   <= '0;
      busrq_n  <= 1'b1;
      dma_cs   <= 1'b0;
      AD_DMA   <= '0;
      obj_we   <= 1'b0;
      obj_addr <= '0;
      obj_data <= '0;
      obj_bank <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (cen) begin
      r_vbl  <= VB;
      r_rd_v <= r_st == COPY;
      r_rd_a <= AD_DMA;
      obj_we <= r_rd_v;
      if (r_rd_v) begin
        obj_addr <= r_rd_a;
        obj_data <= DD_DMA;
      end
      done <= 1'b0;
      case (r_st)
        IDLE: if (w_start) begin
          r_st    <= REQ;
          busrq_n <= 1'b0;
          busy    <= 1'b1;
        end
        REQ: if (!busak_n) begin
          r_st   <= COPY;
          dma_cs <= 1'b1;
          AD_DMA <= '0;
        end
        COPY: if (w_last) begin
          r_st   <= FLUSH;
          r_fcnt <= 1'b0;
        end else AD_DMA <= AD_DMA + 10'd1;
        FLUSH: if (r_fcnt == 1'(FLUSH_DEPTH - 1)) begin
          r_st     <= REL;
          busrq_n  <= 1'b1;
          dma_cs   <= 1'b0;
          done     <= 1'b1;
          obj_bank <= ~obj_bank;
        end else r_fcnt <= r_fcnt + 1'b1;
        REL: begin
          r_st <= IDLE;
          busy <= 1'b0;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtpopeye_dma.sv
// tb_jtpopeye_dma: directed scenarios for jtpopeye_dma with a registered RAM model and a Z80 grant model.
module tb_jtpopeye_dma;
  logic clk = 0, rst_n = 0, cen = 0, VB = 0, busak_n = 1;
  logic [7:0] dd = 0;
  logic busrq_n, dma_cs, obj_we, obj_bank, busy, done;
  logic [9:0] ad, obj_addr;
  logic [7:0] obj_data;
  logic cen1 = 0, VB1 = 0, busak1_n = 1;
  logic [7:0] dd1 = 0;
  logic busrq1_n, dma_cs1, obj_we1, obj_bank1, busy1, done1;
  logic [9:0] ad1, obj_addr1;
  logic [7:0] obj_data1;
  logic [7:0] ram [1024];
  logic [9:0] wa [2048];
  logic [7:0] wd [2048];
  int errors = 0, checks = 0;
  int wr_n, done_n;
  bit timeout, pg_bad;
  logic s_busrq, s_cs, s_bank, s_we;

  jtpopeye_dma u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .busrq_n(busrq_n), .busak_n(busak_n),
    .dma_cs(dma_cs), .AD_DMA(ad), .DD_DMA(dd), .obj_we(obj_we), .obj_addr(obj_addr),
    .obj_data(obj_data), .obj_bank(obj_bank), .busy(busy), .done(done)
  );

  jtpopeye_dma #(.LEN(11'd1)) u_one (
    .clk(clk), .rst_n(rst_n), .cen(cen1), .VB(VB1), .busrq_n(busrq1_n), .busak_n(busak1_n),
    .dma_cs(dma_cs1), .AD_DMA(ad1), .DD_DMA(dd1), .obj_we(obj_we1), .obj_addr(obj_addr1),
    .obj_data(obj_data1), .obj_bank(obj_bank1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (cen) dd <= ram[ad];
  always @(posedge clk) if (cen1) dd1 <= ram[ad1];

  // Runs one transfer on u_dut: grants the bus gdelay ticks after the request,
  // optionally re-pulses VB at write vb_inj, optionally resets at write address rst_at.
  task automatic observe(input int max_clks, input int gdelay, input int vb_inj, input int rst_at);
    int g;
    bit seen, granted, pd;
    wr_n = 0; done_n = 0; timeout = 1; pg_bad = 0;
    g = 0; seen = 0; granted = 0; pd = 0;
    for (int c = 0; c < max_clks; c++) begin
      @(negedge clk);
      if (!rst_n) begin
        s_busrq = busrq_n; s_cs = dma_cs; s_bank = obj_bank; s_we = obj_we;
        rst_n = 1;
      end
      if (c == 4) VB = 0;
      if (obj_we) begin
        if (wr_n < 2048) begin
          wa[wr_n] = obj_addr;
          wd[wr_n] = obj_data;
        end
        wr_n++;
        if (rst_at >= 0 && int'(obj_addr) == rst_at) rst_n = 0;
      end
      if (done && !pd) done_n++;
      pd = done;
      if (vb_inj >= 0 && wr_n == vb_inj) VB = 1;
      if (vb_inj >= 0 && wr_n == vb_inj + 5) VB = 0;
      if (!granted && g > 0 && (busrq_n || dma_cs || obj_we)) pg_bad = 1;
      if (!busrq_n) begin
        if (g == gdelay) begin
          busak_n = 0;
          granted = 1;
        end
        g++;
      end else busak_n = 1;
      if (busy) seen = 1;
      else if (seen) begin
        timeout = 0;
        break;
      end
    end
    VB = 0;
  endtask

  task automatic fill_ram(input int kind);
    for (int i = 0; i < 1024; i++) ram[i] = kind == 0 ? (8'(i) ^ 8'h5A) : 8'(i * 37 + 11);
  endtask

  task automatic check_frame(input string name, input int n, input int bank);
    int bad;
    bad = 0;
    for (int i = 0; i < n && i < wr_n && i < 2048; i++) if (wa[i] !== 10'(i) || wd[i] !== ram[i]) bad++;
    checks++;
    if (timeout) begin errors++; $display("FAIL %s_timeout got=timeout exp=transfer completes", name); end
    checks++;
    if (wr_n !== n) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", name, wr_n, n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_data got=%0d bad writes exp=0", name, bad); end
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL %s_done got=%0d pulses exp=1", name, done_n); end
    checks++;
    if ({busrq_n, dma_cs, busy, obj_bank} !== {3'b100, 1'(bank)})
      begin errors++; $display("FAIL %s_end got=%b exp=%b", name, {busrq_n, dma_cs, busy, obj_bank}, {3'b100, 1'(bank)}); end
  endtask

  task automatic test_reset();
    rst_n = 0; cen = 0; cen1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busrq_n, dma_cs, obj_we, obj_bank, busy, done} !== 6'b100000)
      begin errors++; $display("FAIL reset_ctrl got=%b exp=100000", {busrq_n, dma_cs, obj_we, obj_bank, busy, done}); end
    checks++;
    if ({ad, obj_addr, obj_data} !== 28'd0)
      begin errors++; $display("FAIL reset_data got=%h exp=0", {ad, obj_addr, obj_data}); end
    checks++;
    if ({busrq1_n, dma_cs1, obj_we1, obj_bank1, busy1, done1} !== 6'b100000)
      begin errors++; $display("FAIL reset_one got=%b exp=100000", {busrq1_n, dma_cs1, obj_we1, obj_bank1, busy1, done1}); end
    rst_n = 1; cen = 1;
    repeat (5) @(negedge clk);
    checks++;
    if ({busrq_n, busy} !== 2'b10) begin errors++; $display("FAIL idle_no_vb got=%b exp=10", {busrq_n, busy}); end
  endtask

  task automatic test_transfer();
    fill_ram(0);
    VB = 1;
    observe(3000, 3, -1, -1);
    check_frame("xfer", 1024, 1);
  endtask

  task automatic test_frame2();
    fill_ram(1);
    VB = 1;
    observe(3000, 3, -1, -1);
    check_frame("frame2", 1024, 0);
  endtask

  task automatic test_no_grant();
    fill_ram(0);
    VB = 1;
    observe(4000, 500, -1, -1);
    checks++;
    if (pg_bad) begin errors++; $display("FAIL nogrant_wait got=activity before grant exp=busrq_n=0 only"); end
    check_frame("nogrant", 1024, 1);
  endtask

  task automatic test_reset_mid();
    int late;
    fill_ram(1);
    VB = 1;
    observe(3000, 3, -1, 300);
    checks++;
    if ({s_busrq, s_cs, s_bank, s_we} !== 4'b1000)
      begin errors++; $display("FAIL rstmid_release got=%b exp=1000", {s_busrq, s_cs, s_bank, s_we}); end
    checks++;
    if (wr_n !== 301) begin errors++; $display("FAIL rstmid_count got=%0d exp=301", wr_n); end
    late = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (obj_we) late++;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL rstmid_late_we got=%0d exp=0", late); end
    VB = 1;
    observe(3000, 3, -1, -1);
    check_frame("rstmid_next", 1024, 1);
  endtask

  task automatic test_vb_mid();
    fill_ram(0);
    VB = 1;
    observe(3000, 3, 100, -1);
    check_frame("vbmid", 1024, 0);
    repeat (20) @(negedge clk);
    checks++;
    if ({busy, busrq_n} !== 2'b01) begin errors++; $display("FAIL vbmid_queued got=%b exp=01", {busy, busrq_n}); end
  endtask

  task automatic test_len1();
    int wn, dw, ww, dlast, blow;
    bit seen, pwe, done_ok;
    logic [9:0] a1;
    logic [7:0] d1;
    wn = 0; dw = 0; ww = 0; dlast = -1; blow = -1; seen = 0; pwe = 0; done_ok = 0;
    a1 = 10'h3FF; d1 = 0;
    fill_ram(1);
    VB1 = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (obj_we1) begin
        ww++;
        if (!pwe) begin wn++; a1 = obj_addr1; d1 = obj_data1; end
      end
      pwe = obj_we1;
      if (done1) begin dw++; dlast = c; end
      busak1_n = busrq1_n;
      if (busy1) seen = 1;
      else if (seen) begin blow = c; done_ok = 1; break; end
      cen1 = (c % 4) == 3;
    end
    cen1 = 0; VB1 = 0;
    checks++;
    if (!done_ok) begin errors++; $display("FAIL len1_timeout got=timeout exp=transfer completes"); end
    checks++;
    if (wn !== 1 || ww !== 4) begin errors++; $display("FAIL len1_writes got=%0d writes %0d clks exp=1 writes 4 clks", wn, ww); end
    checks++;
    if (a1 !== 10'd0 || d1 !== ram[0]) begin errors++; $display("FAIL len1_byte got=%h/%h exp=000/%h", a1, d1, ram[0]); end
    checks++;
    if (dw !== 4) begin errors++; $display("FAIL len1_done_width got=%0d exp=4", dw); end
    checks++;
    if (blow !== dlast + 1) begin errors++; $display("FAIL len1_busy_fall got=%0d exp=%0d", blow, dlast + 1); end
    checks++;
    if (obj_bank1 !== 1'b1) begin errors++; $display("FAIL len1_bank got=%b exp=1", obj_bank1); end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_frame2();
    test_no_grant();
    test_reset_mid();
    test_vb_mid();
    test_len1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
